imm_encoder: RTL and testbench

//  Inverse of the decode-side immediate extraction. Packs an opcode, register fields and a
//  32-bit immediate into a 32-bit RV32 instruction word for the selected immediate format.

---
 rtl/imm_encoder_pkg.sv | 29 ++
 rtl/imm_encoder_pack.sv | 40 ++++
 rtl/imm_encoder.sv | 116 +++++++++++
 tb/tb_imm_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared encoding constants for the instruction-injection path.
// Immediate-format selectors, word widths and the base-opcode helper.
package imm_encoder_pkg;

  localparam int DATA_LEN       = 32;
  localparam int INSN_LEN       = 32;
  localparam int IMM_TYPE_WIDTH = 2;

  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = 2'd0;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = 2'd1;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = 2'd2;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = 2'd3;

  // True when every bit of the slice is a copy of the same sign bit.
  function automatic logic all_equal(input logic [DATA_LEN-1:0] value, input int lo);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < DATA_LEN; i++) begin
      if (i >= lo) begin
        ones  = ones & value[i];
        zeros = zeros & ~value[i];
      end
    end
    return ones | zeros;
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Scatters a two's-complement immediate into its RV32 bit positions for one format
// and flags values the format cannot represent.
module imm_encoder_pack
  import imm_encoder_pkg::*;
(
  input  logic [DATA_LEN-1:0]       imm,
  input  logic [IMM_TYPE_WIDTH-1:0] imm_type,
  output logic [INSN_LEN-1:0]       imm_bits,
  output logic                      range_err
);

  always_comb begin
    imm_bits  = '0;
    range_err = 1'b0;
    case (imm_type)
      IMM_I: begin
        imm_bits[31:20] = imm[11:0];
        range_err       = ~all_equal(imm, 11);
      end
      IMM_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        range_err       = ~all_equal(imm, 11);
      end
      IMM_U: begin
        imm_bits[31:12] = imm[31:12];
        range_err       = |imm[11:0];
      end
      default: begin
        // J keeps bit 20 as the sign, so bits 31:20 must all agree.
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        range_err       = imm[0] | ~all_equal(imm, 20);
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder: S1 registers the request and range-checks the immediate,
// S2 holds the assembled instruction word and keeps delivery statistics.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                in_opcode,
  input  logic [4:0]                in_rd,
  input  logic [2:0]                in_funct3,
  input  logic [4:0]                in_rs1,
  input  logic [4:0]                in_rs2,
  input  logic [DATA_LEN-1:0]       in_imm,
  input  logic [IMM_TYPE_WIDTH-1:0] in_type,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSN_LEN-1:0]       out_inst,
  output logic                      out_err,
  output logic [CNT_W-1:0]          enc_count,
  output logic [CNT_W-1:0]          err_count
);

  logic                      s1_valid;
  logic [6:0]                s1_opcode;
  logic [4:0]                s1_rd;
  logic [2:0]                s1_funct3;
  logic [4:0]                s1_rs1;
  logic [4:0]                s1_rs2;
  logic [DATA_LEN-1:0]       s1_imm;
  logic [IMM_TYPE_WIDTH-1:0] s1_type;
  logic [INSN_LEN-1:0]       imm_bits;
  logic                      range_err;
  logic [INSN_LEN-1:0]       asm_inst;
  logic                      s2_adv;
  logic                      s1_adv;
  logic                      out_fire;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv & ~reset;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_funct3 <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
      s1_type   <= IMM_I;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_opcode <= in_opcode;
        s1_rd     <= in_rd;
        s1_funct3 <= in_funct3;
        s1_rs1    <= in_rs1;
        s1_rs2    <= in_rs2;
        s1_imm    <= in_imm;
        s1_type   <= in_type;
      end
    end
  end

  imm_encoder_pack u_pack (
    .imm       (s1_imm),
    .imm_type  (s1_type),
    .imm_bits  (imm_bits),
    .range_err (range_err)
  );

  // Register fields are merged only for the formats that own them; the rest stay zero.
  always_comb begin
    asm_inst      = imm_bits;
    asm_inst[6:0] = s1_opcode;
    if (s1_type != IMM_S)
      asm_inst[11:7] = s1_rd;
    if ((s1_type == IMM_I) || (s1_type == IMM_S)) begin
      asm_inst[14:12] = s1_funct3;
      asm_inst[19:15] = s1_rs1;
    end
    if (s1_type == IMM_S)
      asm_inst[24:20] = s1_rs2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= asm_inst | imm_bits;
        out_err  <= range_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_fire) begin
      enc_count <= enc_count + 1'b1;
      err_count <= err_count + {{(CNT_W-1){1'b0}}, out_err};
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed scoreboard bench for imm_encoder: expected words are queued on accept
// and compared with immediate assertions when the encoder delivers them.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic [1:0]  in_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  exp_t        sb[$];
  exp_t        pend;
  logic        accepted;
  logic [15:0] exp_enc;
  logic [15:0] exp_errs;
  int          delivered;
  int          checks;
  int          failures;
  logic [31:0] held_inst;

  imm_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .in_type   (in_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(output logic err_bit);
    exp_t e;
    err_bit = 1'b0;
    if (sb.size() == 0) begin
      compare("unexpected_output", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      compare("out_inst", out_inst, e.inst);
      compare("out_err", {31'd0, out_err}, {31'd0, e.err});
      err_bit = e.err;
    end
  endtask

  // One clock cycle: observe handshakes before the edge, update the model, check counters after it.
  task automatic step();
    logic out_acc;
    logic in_acc;
    logic err_bit;
    err_bit = 1'b0;
    #1;
    out_acc = out_valid && out_ready && !reset;
    in_acc  = in_valid && in_ready;
    if (out_acc) checkOutput(err_bit);
    if (in_acc) begin
      sb.push_back(pend);
      accepted = 1'b1;
    end
    @(posedge clk);
    if (reset) begin
      exp_enc  = '0;
      exp_errs = '0;
      sb.delete();
    end else if (out_acc) begin
      exp_enc++;
      delivered++;
      if (err_bit) exp_errs++;
    end
    @(negedge clk);
    compare("enc_count", {16'd0, enc_count}, {16'd0, exp_enc});
    compare("err_count", {16'd0, err_count}, {16'd0, exp_errs});
  endtask

  task automatic setReq(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [1:0] ty, input logic [31:0] exp_inst, input logic exp_err);
    in_opcode = op;
    in_rd     = rd;
    in_funct3 = f3;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_type   = ty;
    pend.inst = exp_inst;
    pend.err  = exp_err;
    in_valid  = 1'b1;
    accepted  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [1:0] ty, input logic [31:0] exp_inst, input logic exp_err);
    setReq(op, rd, f3, rs1, rs2, imm, ty, exp_inst, exp_err);
    for (int i = 0; i < 20 && !accepted; i++) step();
    if (!accepted) compare("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    compare("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    #1;
    compare("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    delivered = 0;
    exp_enc = '0;
    exp_errs = '0;
    accepted = 1'b0;
    pend = '0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_type = IMM_I;
    @(negedge clk);
    @(negedge clk);
    compare("rst_out_valid", {31'd0, out_valid}, 32'd0);
    compare("rst_out_inst", out_inst, 32'd0);
    compare("rst_out_err", {31'd0, out_err}, 32'd0);
    compare("rst_enc_count", {16'd0, enc_count}, 32'd0);
    compare("rst_err_count", {16'd0, err_count}, 32'd0);
    compare("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;

    $display("[TB] I-format and latency");
    applyStimulus(7'h13, 5'd1, 3'd0, 5'd0, 5'd31, 32'hFFFF_FFFF, IMM_I, 32'hFFF0_0093, 1'b0);
    compare("latency_before", {31'd0, out_valid}, 32'd0);
    step();
    compare("latency_after", {31'd0, out_valid}, 32'd1);
    drain();

    $display("[TB] S-format");
    applyStimulus(7'h23, 5'd9, 3'b010, 5'd3, 5'd2, 32'd8, IMM_S, 32'h0021_A423, 1'b0);
    applyStimulus(7'h23, 5'd9, 3'b010, 5'd3, 5'd2, 32'h0000_0800, IMM_S, 32'h8021_A023, 1'b1);
    drain();

    $display("[TB] U-format");
    applyReset();
    out_ready = 1'b1;
    applyStimulus(7'h37, 5'd5, 3'd7, 5'd31, 5'd31, 32'h1234_5000, IMM_U, 32'h1234_52B7, 1'b0);
    applyStimulus(7'h37, 5'd5, 3'd7, 5'd31, 5'd31, 32'h1234_5001, IMM_U, 32'h1234_52B7, 1'b1);
    drain();
    compare("u_err_count", {16'd0, err_count}, 32'd1);

    $display("[TB] J-format");
    applyStimulus(7'h6F, 5'd1, 3'd5, 5'd7, 5'd7, 32'h0000_0800, IMM_J, 32'h0010_00EF, 1'b0);
    applyStimulus(7'h6F, 5'd1, 3'd5, 5'd7, 5'd7, 32'h0010_0000, IMM_J, 32'h8000_00EF, 1'b1);
    applyStimulus(7'h6F, 5'd1, 3'd5, 5'd7, 5'd7, 32'h0000_0003, IMM_J, 32'h0020_00EF, 1'b1);
    drain();

    $display("[TB] Backpressure");
    applyReset();
    out_ready = 1'b0;
    applyStimulus(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 32'd5, IMM_I, 32'h0050_0113, 1'b0);
    applyStimulus(7'h37, 5'd3, 3'd0, 5'd0, 5'd0, 32'hABCD_E000, IMM_U, 32'hABCD_E1B7, 1'b0);
    setReq(7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 32'h0000_0010, IMM_J, 32'h0100_006F, 1'b0);
    step();
    compare("bp_third_blocked", {31'd0, accepted}, 32'd0);
    compare("bp_in_ready", {31'd0, in_ready}, 32'd0);
    held_inst = out_inst;
    step();
    compare("bp_out_stable", out_inst, held_inst);
    compare("bp_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    delivered = 0;
    step();
    compare("bp_third_accepted", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
    step();
    step();
    compare("bp_delivered", delivered, 32'd3);
    compare("bp_enc_count", {16'd0, enc_count}, 32'd3);
    compare("bp_queue_empty", sb.size(), 32'd0);

    $display("[TB] Reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(7'h13, 5'd4, 3'd0, 5'd0, 5'd0, 32'd1, IMM_I, 32'h0010_0213, 1'b0);
    applyStimulus(7'h13, 5'd6, 3'd0, 5'd0, 5'd0, 32'd2, IMM_I, 32'h0020_0313, 1'b0);
    step();
    compare("mid_out_valid_before", {31'd0, out_valid}, 32'd1);
    applyReset();
    compare("mid_out_valid", {31'd0, out_valid}, 32'd0);
    compare("mid_enc_count", {16'd0, enc_count}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      compare("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
